// File: rtl/store_m_if.sv
// store_m_if: command, tile handshake and byte write-port bundle for store_m.
// Modports: master drives command/tile inputs; slave is the store_m view.
interface store_m_if #(
  parameter int TILE_WIDTH = 256
);
  logic                  valid_in;
  logic [23:0]           dram_addr;
  logic [19:0]           length;
  logic                  ready_out;
  logic                  busy;
  logic [TILE_WIDTH-1:0] tile_in;
  logic                  tile_valid;
  logic                  tile_ready;
  logic                  mem_we;
  logic [23:0]           mem_addr;
  logic [7:0]            mem_din;
  logic                  valid_out;

  modport master (
    output valid_in, dram_addr, length,
    output tile_in, tile_valid,
    input  ready_out, busy, tile_ready,
    input  mem_we, mem_addr, mem_din,
    input  valid_out
  );

  modport slave (
    input  valid_in, dram_addr, length,
    input  tile_in, tile_valid,
    output ready_out, busy, tile_ready,
    output mem_we, mem_addr, mem_din,
    output valid_out
  );
endinterface

// File: rtl/store_m.sv
// store_m: takes a store command, then serialises TILE_WIDTH-bit tiles
// MSB-byte-first onto a byte-wide write port. Ports: clk, rst, bus (slave).
module store_m #(
  parameter int TILE_WIDTH = 256
) (
  input logic      clk,
  input logic      rst,
  store_m_if.slave bus
);
  localparam int NUM_BYTES = TILE_WIDTH / 8;
  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TILE,
    WRITING,
    DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [23:0]           cur_addr;
  logic [17:0]           bytes_left;
  logic [CW-1:0]         byte_cnt;
  logic [TILE_WIDTH-1:0] shift;
  logic [17:0]           len_bytes;
  logic                  last_byte;
  logic                  last_in_tile;

  // Round bit length up to whole bytes; the 21-bit sum cannot overflow.
  assign len_bytes =
    18'(({1'b0, bus.length} + 21'd7) >> 3);

  assign last_byte    = (bytes_left == 18'd1);
  assign last_in_tile = (byte_cnt == CW'(NUM_BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.valid_in) begin
          if (len_bytes == 18'd0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT_TILE;
          end
        end
      end
      WAIT_TILE: begin
        if (bus.tile_valid) begin
          state_nxt = WRITING;
        end
      end
      WRITING: begin
        if (last_byte) begin
          state_nxt = DONE;
        end else if (last_in_tile) begin
          state_nxt = WAIT_TILE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: command capture, tile load, per-byte shift/advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr   <= '0;
      bytes_left <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.valid_in) begin
            cur_addr   <= bus.dram_addr;
            bytes_left <= len_bytes;
          end
        end
        WAIT_TILE: begin
          if (bus.tile_valid) begin
            shift    <= bus.tile_in;
            byte_cnt <= '0;
          end
        end
        WRITING: begin
          shift      <= shift << 8;
          cur_addr   <= cur_addr + 24'd1;
          bytes_left <= bytes_left - 18'd1;
          byte_cnt   <= byte_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs depend on registered state only; reset clears them at once.
  assign bus.ready_out  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.tile_ready = (state == WAIT_TILE);
  assign bus.mem_we     = (state == WRITING);
  assign bus.valid_out  = (state == DONE);
  assign bus.mem_addr   =
    (state == WRITING) ? cur_addr : 24'd0;
  assign bus.mem_din    =
    (state == WRITING) ? shift[TILE_WIDTH-1 -: 8] : 8'd0;
endmodule

// File: tb/tb_store_m.sv
// tb_store_m: randomized scoreboard bench for store_m.
// Byte-stream model feeds an expected-write queue; a monitor pops and compares.
module tb_store_m;
  localparam int TW = 256;
  localparam int NB = TW / 8;

  typedef struct {
    bit          done;
    bit          after_we;
    logic [23:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  bit   prev_we;
  exp_t e;
  exp_t exp_q[$];

  store_m_if #(.TILE_WIDTH(TW)) bus();

  store_m #(.TILE_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (bus.mem_we) begin
        n_vec++;
        if (exp_q.size() == 0 || exp_q[0].done) begin
          n_err++;
          $display("FAIL unexpected_write: addr %h data %h",
                   bus.mem_addr, bus.mem_din);
        end else begin
          e = exp_q.pop_front();
          if (bus.mem_addr !== e.addr || bus.mem_din !== e.data) begin
            n_err++;
            $display("FAIL write: got %h/%h want %h/%h",
                     bus.mem_addr, bus.mem_din, e.addr, e.data);
          end
        end
      end
      if (bus.valid_out) begin
        n_vec++;
        if (exp_q.size() == 0 || !exp_q[0].done) begin
          n_err++;
          $display("FAIL unexpected_done: pending %0d", exp_q.size());
        end else begin
          e = exp_q.pop_front();
          if (e.after_we && !prev_we) begin
            n_err++;
            $display("FAIL done_timing: prev_we %0b want 1", prev_we);
          end
        end
      end
      prev_we = bus.mem_we;
    end
  end

  task automatic run_cmd(input logic [23:0] base,
                         input logic [19:0] len,
                         input bit seq,
                         input int gap,
                         input bit hold,
                         input bit bp);
    int              nb;
    int              nt;
    int              w;
    logic [7:0]      bq[$];
    logic [TW-1:0]   t;
    logic [23:0]     a;
    nb = (int'(len) + 7) / 8;
    nt = (nb + NB - 1) / NB;
    for (int i = 0; i < nt * NB; i++) begin
      bq.push_back(seq ? 8'(i) : 8'($urandom));
    end
    for (int j = 0; j < nb; j++) begin
      a = base + 24'(j);
      exp_q.push_back('{done: 1'b0, after_we: 1'b0,
                        addr: a, data: bq[j]});
    end
    exp_q.push_back('{done: 1'b1, after_we: (nb > 0),
                      addr: 24'h0, data: 8'h0});

    @(posedge clk); #1;
    bus.valid_in  = 1'b1;
    bus.dram_addr = base;
    bus.length    = len;
    @(posedge clk); #1;
    bus.valid_in  = 1'b0;
    bus.dram_addr = 24'($urandom);
    bus.length    = 20'($urandom);

    if (nb == 0) begin
      @(negedge clk);
      chk("zero_len_done", 32'(bus.valid_out), 1);
      chk("zero_len_no_tile", 32'(bus.tile_ready), 0);
      @(negedge clk);
      chk("zero_len_ready", 32'(bus.ready_out), 1);
      return;
    end

    for (int k = 0; k < nt; k++) begin
      for (int i = 0; i < NB; i++) begin
        t[TW-1-8*i -: 8] = bq[k*NB+i];
      end
      if (!hold || k == 0) begin
        if (bp && k == 0) begin
          for (int g = 0; g < 10; g++) begin
            @(negedge clk);
            chk("bp_tile_ready", 32'(bus.tile_ready), 1);
            chk("bp_no_write", 32'(bus.mem_we), 0);
            if (g == 3) begin
              bus.valid_in  = 1'b1;
              bus.dram_addr = 24'hABCDEF;
              bus.length    = 20'd8;
            end else begin
              bus.valid_in = 1'b0;
            end
          end
        end else begin
          repeat (gap) @(posedge clk);
        end
        @(posedge clk); #1;
      end
      bus.tile_in    = t;
      bus.tile_valid = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!bus.tile_ready && w < 300);
      chk("tile_ready_wait", 32'(bus.tile_ready), 1);
      @(posedge clk); #1;
      bus.tile_valid = hold && (k + 1 < nt);
      @(negedge clk);
      chk("write_after_accept", 32'(bus.mem_we), 1);
      a = base + 24'(k * NB);
      chk("first_addr_of_tile", 32'(bus.mem_addr), 32'(a));
    end
    bus.tile_valid = 1'b0;

    w = 0;
    while (!bus.valid_out && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", 32'(bus.valid_out), 1);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.valid_out), 0);
    chk("ready_after_done", 32'(bus.ready_out), 1);
  endtask

  task automatic reset_mid_write();
    logic [TW-1:0] t;
    logic [7:0]    b;
    for (int i = 0; i < NB; i++) begin
      b = 8'($urandom);
      t[TW-1-8*i -: 8] = b;
      if (i < 6) begin
        exp_q.push_back('{done: 1'b0, after_we: 1'b0,
                          addr: 24'h000300 + 24'(i), data: b});
      end
    end
    @(posedge clk); #1;
    bus.valid_in  = 1'b1;
    bus.dram_addr = 24'h000300;
    bus.length    = 20'd256;
    @(posedge clk); #1;
    bus.valid_in   = 1'b0;
    bus.tile_in    = t;
    bus.tile_valid = 1'b1;
    @(posedge clk); #1;
    bus.tile_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_we", 32'(bus.mem_we), 0);
    chk("rst_async_busy", 32'(bus.busy), 0);
    chk("rst_async_tready", 32'(bus.tile_ready), 0);
    chk("rst_async_ready", 32'(bus.ready_out), 1);
    chk("rst_bytes_written", 32'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_idle_no_done", 32'(bus.valid_out), 0);
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    prev_we        = 1'b0;
    rst            = 1'b1;
    bus.valid_in   = 1'b0;
    bus.dram_addr  = '0;
    bus.length     = '0;
    bus.tile_in    = '0;
    bus.tile_valid = 1'b0;

    @(negedge clk);
    chk("rst_ready_out", 32'(bus.ready_out), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_din", 32'(bus.mem_din), 0);
    chk("rst_tile_ready", 32'(bus.tile_ready), 0);
    chk("rst_valid_out", 32'(bus.valid_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_cmd(24'h000100, 20'd256, 1'b1, 0, 1'b0, 1'b0);
    run_cmd(24'h000200, 20'd600, 1'b0, 2, 1'b0, 1'b0);
    run_cmd(24'h000200, 20'd600, 1'b0, 0, 1'b1, 1'b0);
    run_cmd(24'h000400, 20'd9,   1'b0, 0, 1'b0, 1'b0);
    run_cmd(24'h000500, 20'd0,   1'b0, 0, 1'b0, 1'b0);
    run_cmd(24'h000600, 20'd64,  1'b0, 0, 1'b0, 1'b1);
    run_cmd(24'hFFFFFE, 20'd32,  1'b0, 0, 1'b0, 1'b0);
    reset_mid_write();
    run_cmd(24'h000010, 20'd8,   1'b0, 0, 1'b0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      run_cmd(24'($urandom),
              20'($urandom_range(0, 800)),
              1'b0,
              int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)),
              1'b0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
